hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_decoder.sv | 108 ++++++++++
 tb/tb_hamming_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(11,7) decoder with valid/ready handshakes and saturating
// counters of corrected and uncorrectable words delivered to the sink.
module hamming_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_data,
  output logic [3:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] unc_cnt
);

  localparam int unsigned CODE_W = 11;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned SYN_W  = 4;
  localparam logic [SYN_W-1:0] SYN_LAST = SYN_W'(CODE_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [SYN_W-1:0]  s1_syn;

  logic [SYN_W-1:0]  syn_c;
  logic              s2_load_c;
  logic              fix_c;
  logic              bad_c;
  logic [CODE_W-1:0] flip_c;
  logic [CODE_W-1:0] word_c;
  logic [DATA_W-1:0] data_c;
  logic              xfer_c;

  // Syndrome: XOR of 1-based positions of every set bit.
  always_comb begin
    syn_c = '0;
    for (int i = 0; i < int'(CODE_W); i++) begin
      if (in_code[i]) syn_c = syn_c ^ SYN_W'(i + 1);
    end
  end

  assign s2_load_c = s1_valid && (!out_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load_c;
  assign xfer_c    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= syn_c;
      end
    end
  end

  // Syndromes beyond the last codeword position cannot name a bit: pass through.
  always_comb begin
    fix_c  = (s1_syn != '0) && (s1_syn <= SYN_LAST);
    bad_c  = (s1_syn > SYN_LAST);
    flip_c = fix_c ? (CODE_W'(1) << (s1_syn - SYN_W'(1))) : '0;
    word_c = s1_code ^ flip_c;
    data_c = {word_c[10:8], word_c[6:4], word_c[2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (s2_load_c) begin
      out_valid         <= 1'b1;
      out_data          <= data_c;
      out_syndrome      <= s1_syn;
      out_corrected     <= fix_c;
      out_uncorrectable <= bad_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      unc_cnt  <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
      unc_cnt  <= '0;
    end else if (xfer_c) begin
      if (out_corrected && (corr_cnt != CNT_MAX)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_uncorrectable && (unc_cnt != CNT_MAX)) unc_cnt <= unc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder (CNT_W=2): decode cases, back-pressure,
// counter saturation/clear and mid-stream reset.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [10:0] in_code = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] out_data;
  logic [3:0] out_syndrome;
  logic       out_corrected;
  logic       out_uncorrectable;
  logic       clr_cnt = 1'b0;
  logic [1:0] corr_cnt;
  logic [1:0] unc_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [6:0]  DATA = 7'b1011001;
  localparam logic [10:0] BASE = 11'h54E;

  hamming_decoder #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable), .clr_cnt(clr_cnt),
    .corr_cnt(corr_cnt), .unc_cnt(unc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    tests_run++;
    if (out_data !== 7'd0 || out_syndrome !== 4'd0 || out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out: data=%h syn=%h c=%b u=%b want all 0", out_data, out_syndrome, out_corrected, out_uncorrectable);
    end
    tests_run++;
    if (corr_cnt !== 2'd0 || unc_cnt !== 2'd0) begin
      tests_failed++; $display("FAIL reset_cnt: corr=%0d unc=%0d want 0/0", corr_cnt, unc_cnt);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one word with out_ready=1; check 2-cycle latency, fields and counters.
  task automatic test_word(input string name, input logic [10:0] code, input logic [3:0] syn,
                           input logic c, input logic u, input logic [1:0] ecorr, input logic [1:0] eunc);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_code = code;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s_accept: in_ready=%b want 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_code = 11'h7FF;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL %s_early: out_valid=%b want 0 after 1 cycle", name, out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== DATA || out_syndrome !== syn || out_corrected !== c || out_uncorrectable !== u) begin
      tests_failed++;
      $display("FAIL %s_out: v=%b data=%b syn=%0d c=%b u=%b want 1/%b/%0d/%b/%b",
               name, out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable, DATA, syn, c, u);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || corr_cnt !== ecorr || unc_cnt !== eunc) begin
      tests_failed++; $display("FAIL %s_cnt: v=%b corr=%0d unc=%0d want 0/%0d/%0d", name, out_valid, corr_cnt, unc_cnt, ecorr, eunc);
    end
  endtask

  task automatic test_clean();
    test_word("clean", BASE, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_single_error();
    test_word("single", 11'h56E, 4'd6, 1'b1, 1'b0, 2'd1, 2'd0);
    test_word("parity0", 11'h54F, 4'd1, 1'b1, 1'b0, 2'd2, 2'd0);
  endtask

  task automatic test_invalid_syndrome();
    test_word("invalid", 11'h5C6, 4'd12, 1'b0, 1'b1, 2'd2, 2'd1);
  endtask

  // Five words with syndromes 1..5 (ordering tag); sink stalls 4 cycles while full.
  task automatic test_back_pressure();
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    logic [10:0] one;
    while (rcvd < 5 && cyc < 60) begin
      @(negedge clk);
      one = 11'd1 << sent;
      in_valid  = (sent < 5);
      in_code   = BASE ^ one;
      out_ready = (cyc >= 6);
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_syndrome !== 4'd1 || out_data !== DATA) begin
          tests_failed++;
          $display("FAIL bp_stall%0d: in_ready=%b v=%b syn=%0d data=%b want 0/1/1/%b", cyc, in_ready, out_valid, out_syndrome, out_data, DATA);
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (out_syndrome !== 4'(rcvd + 1) || out_data !== DATA || out_corrected !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_order%0d: syn=%0d data=%b c=%b want %0d/%b/1", rcvd, out_syndrome, out_data, out_corrected, rcvd + 1, DATA);
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (rcvd != 5 || sent != 5) begin
      tests_failed++; $display("FAIL bp_count: rcvd=%0d sent=%0d want 5/5", rcvd, sent);
    end
    @(negedge clk);
    tests_run++;
    if (corr_cnt !== 2'd3 || unc_cnt !== 2'd1) begin
      tests_failed++; $display("FAIL bp_saturate: corr=%0d unc=%0d want 3/1", corr_cnt, unc_cnt);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_dup: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_code = BASE;
    @(negedge clk);
    in_code = 11'h56E;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL rst_full: v=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || corr_cnt !== 2'd0 || unc_cnt !== 2'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_async: v=%b corr=%0d unc=%0d in_ready=%b want 0/0/0/1", out_valid, corr_cnt, unc_cnt, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_word("post_rst", 11'h56E, 4'd6, 1'b1, 1'b0, 2'd1, 2'd0);
  endtask

  task automatic test_clear();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_code = 11'h56E;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clr_cnt = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_corrected !== 1'b1) begin
      tests_failed++; $display("FAIL clr_setup: v=%b c=%b want 1/1", out_valid, out_corrected);
    end
    @(negedge clk);
    clr_cnt = 1'b0;
    tests_run++;
    if (corr_cnt !== 2'd0 || unc_cnt !== 2'd0) begin
      tests_failed++; $display("FAIL clr_wins: corr=%0d unc=%0d want 0/0", corr_cnt, unc_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_invalid_syndrome();
    test_back_pressure();
    test_reset_mid_stream();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
